// File: rtl/uart_tx_if.sv
// uart_tx_if: send request / status handshake between the loopback stage and uart_tx
interface uart_tx_if;
    logic       send_en;
    logic [7:0] send_data;
    logic       tx_busy;
    logic       tx_done;
    modport master (output send_en, send_data, input tx_busy, tx_done);
    modport slave  (input send_en, send_data, output tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 UART transmitter with optional odd/even parity, one frame per send_en rise
module uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int PARITY   = 0
) (
    input  logic     clk,
    input  logic     sys_rst_n,
    uart_tx_if.slave s_if,
    output logic     o_uart_txd
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam bit P_EN    = (PARITY == 1) || (PARITY == 2);
    localparam int NBITS   = P_EN ? 11 : 10;
    localparam int CW      = $clog2(BPS_CNT);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_en_d0, r_en_d1;
    logic [CW-1:0] r_baud_cnt, w_baud_nxt;
    logic [3:0]    r_bit_idx, w_bit_nxt;
    logic [7:0]    r_tx_reg, w_tx_reg_nxt;
    logic          r_txd, w_txd_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          w_start, w_baud_end, w_last, w_parity, w_next_bit;
    logic [3:0]    w_bit_inc;

    assign w_start    = r_en_d0 & ~r_en_d1;
    assign w_baud_end = r_baud_cnt == CW'(BPS_CNT - 1);
    assign w_last     = r_bit_idx == 4'(NBITS - 1);
    assign w_parity   = (PARITY == 1) ? ~^r_tx_reg : ^r_tx_reg;
    assign w_bit_inc  = r_bit_idx + 4'd1;
    // the bit that goes on the line once the current one has been held for BPS_CNT clocks
    assign w_next_bit = (w_bit_inc <= 4'd8) ? r_tx_reg[3'(w_bit_inc - 4'd1)] :
                        (P_EN && w_bit_inc == 4'd9) ? w_parity : 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud_cnt;
        w_bit_nxt    = r_bit_idx;
        w_tx_reg_nxt = r_tx_reg;
        w_txd_nxt    = r_txd;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        if (r_state == IDLE) begin
            w_txd_nxt  = 1'b1;
            w_busy_nxt = 1'b0;
            if (w_start) begin
                w_state_nxt  = SHIFT;
                w_tx_reg_nxt = s_if.send_data;
                w_baud_nxt   = '0;
                w_bit_nxt    = '0;
                w_txd_nxt    = 1'b0;
                w_busy_nxt   = 1'b1;
            end
        end else if (w_baud_end) begin
            w_baud_nxt = '0;
            if (w_last) begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_txd_nxt   = 1'b1;
            end else begin
                w_bit_nxt = w_bit_inc;
                w_txd_nxt = w_next_bit;
            end
        end else begin
            w_baud_nxt = r_baud_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_en_d0    <= 1'b0;
            r_en_d1    <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx_reg   <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en_d0    <= s_if.send_en;
            r_en_d1    <= r_en_d0;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_tx_reg   <= w_tx_reg_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign o_uart_txd   = r_txd;
    assign s_if.tx_busy = r_busy;
    assign s_if.tx_done = r_done;
endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter that drives the board TX pin. Sits directly downstream of the receive-to-transmit loopback stage: it consumes that stage's `send_en`/`send_data` and returns `tx_busy` so the loopback waits before issuing the next byte. It produces one 8-N-1 frame, with optional parity, per rising edge of `send_en`.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `UART_BPS`, 115200: baud rate.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. Other values are treated as 0.
- Derived `BPS_CNT` = CLK_FREQ / UART_BPS, using integer truncation (434 at the defaults). Must be ≥ 2.

- `clk`  in  1  system clock; reset `sys_rst_n` is asynchronous, active-low; clock is `clk`.
- `sys_rst_n`  in  1  asynchronous reset, active-low.
- `send_en`  in  1  send request; level signal, acted on at its rising edge only.
- `send_data`  in  8  byte to send; sampled in the edge-detect cycle.
- `tx_busy`  out  1  high from the frame's first cycle through its last stop-bit cycle.
- `tx_done`  out  1  one-cycle pulse at frame completion.
- `uart_txd`  out  1  serial line, idle high; registered output.

## Operation
- Edge detect:
  - `send_en` passes through two flops, `en_d0` and `en_d1`.
  - `start_flag` = `en_d0 & ~en_d1`.
  - Holding `send_en` high never retriggers.
- States: IDLE and SHIFT. There are no other states.
- IDLE:
  - `uart_txd` = 1, `tx_busy` = 0.
  - On `start_flag`:
    - latch `send_data` into `tx_reg`;
    - compute the parity bit from `tx_reg` (odd: ~^data; even: ^data);
    - clear `baud_cnt` and `bit_idx`;
    - go to SHIFT.
- SHIFT:
  - `baud_cnt` counts 0..BPS_CNT-1 and wraps to 0.
  - `bit_idx` increments when `baud_cnt` wraps.
  - Bit order on `uart_txd`: start (0), then d0..d7 (LSB first), then parity if enabled, then stop (1).
  - NBITS = 10 without parity, 11 with parity.
  - When `bit_idx` = NBITS-1 and `baud_cnt` = BPS_CNT-1: return to IDLE at the next edge and pulse `tx_done` for exactly one cycle.
- `start_flag` while in SHIFT is ignored. It is not queued.
- Changes on `send_data` after the latch have no effect on the frame in progress.
- Reset values: `uart_txd` = 1, `tx_busy` = 0, `tx_done` = 0; `en_d0`, `en_d1`, counters and `tx_reg` = 0; state = IDLE.
- Reset mid-frame: the line returns high immediately (asynchronous) and the partial frame is abandoned. No `tx_done` is issued.

## Timing
- Latency from a `send_en` rise, registered at edge E:
  - `en_d0` = 1 after edge E+1;
  - `start_flag` is high during the cycle following E+1;
  - at edge E+2, `tx_busy` rises and `uart_txd` falls (start bit).
- Each bit is held for exactly BPS_CNT clocks.
- `tx_busy` stays high for exactly NBITS × BPS_CNT cycles.
- At the edge where `tx_busy` falls, `tx_done` rises for one cycle and `uart_txd` is already 1 (end of stop bit).
- The earliest accepted next request is a `send_en` rise registered in the cycle `tx_busy` is 0. Back-to-back frames are therefore separated by at least 2 idle cycles of line-high, in addition to the stop bit.
- Interaction with the loopback stage:
  - it raises `send_en` only while `tx_busy` = 0;
  - it drops `send_en` when a new byte is received;
  - each received byte therefore produces exactly one rising edge.

## Test plan
- Bench parameters: CLK_FREQ = 1_000_000, UART_BPS = 100_000, giving BPS_CNT = 10.
- Reset release, no stimulus → `uart_txd` = 1, `tx_busy` = 0, `tx_done` = 0 for 200 cycles.
- PARITY = 0, `send_data` = 8'hA5, `send_en` rises → `tx_busy` high 2 edges later for 100 cycles. Line samples at bit centres are 0,1,0,1,0,0,1,0,1,1. `tx_done` is a single pulse at the falling edge of `tx_busy`.
- PARITY = 1, byte 8'h03 → 11 bits, parity bit = 1, `tx_busy` high for 110 cycles. With PARITY = 2 the parity bit = 0.
- During a frame:
  - `send_data` changes to 8'hFF → frame still carries 8'hA5;
  - `send_en` toggles 0→1 → ignored, no second frame;
  - `send_en` held high after the frame → no retrigger.
- Two requests with `send_en` low then high, the second rise registered in the first cycle after `tx_busy` = 0 → second frame's start bit begins exactly 2 cycles later. Both bytes decode correctly.
- `sys_rst_n` asserted at bit 4 of a frame → `uart_txd` = 1 and `tx_busy` = 0 within the same cycle, no `tx_done`. After release, a new request transmits a clean full frame.
